// File: rtl/read_scoreboard.sv
// -----------------------------------------------------------------------------
// read_scoreboard
//
// Register-hazard scoreboard for the register-read stage. It keeps a 2-bit
// in-flight write count per architectural register (16 registers). It also
// counts the IMUL special destination. Read is stalled while a source operand
// (or the implicit RSP read of RETQ) has a pending write. Read is also stalled
// when a destination has already reached MAX_PENDING in-flight writes.
//
// Optional feature macro: READ_SCOREBOARD_WB_BYPASS_EN
//   Defined   : a source with exactly one pending write, retiring this cycle,
//               is not a hazard. The register file writes through, so Read
//               sees the retiring value.
//   Undefined : any nonzero count stalls. Write-back only counts after the edge.
//
// Ports
//   clk, reset                   core clock, synchronous active-high reset
//   flushIn                      clears all pending counts on the next edge
//   issueValidIn                 Read stage holds a decoded instruction
//   sourceReg{1,2}In/ValidIn     source operands
//   opcodeLengthIn, opcodeIn     used to detect RETQ (implicit RSP read)
//   destRegIn/ValidIn            primary destination
//   destRegisterSpecial*In       second destination (IMUL RDX)
//   wbValidIn, wbReg*In          retiring destinations from write-back
//   readStallOut                 combinational stall to the Read stage
//   issueAcceptOut               issueValidIn && !readStallOut
//   pendingMaskOut               registered, bit r = count[r] != 0
//   busyOut                      registered OR of pendingMaskOut
//   underflowErrOut              sticky: write-back hit a zero count
// -----------------------------------------------------------------------------
module read_scoreboard #(
    parameter int MAX_PENDING = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flushIn,
    input  logic        issueValidIn,
    input  logic [0:3]  sourceReg1In,
    input  logic [0:3]  sourceReg2In,
    input  logic        sourceReg1ValidIn,
    input  logic        sourceReg2ValidIn,
    input  logic [0:31] opcodeLengthIn,
    input  logic [0:7]  opcodeIn,
    input  logic [0:3]  destRegIn,
    input  logic        destRegValidIn,
    input  logic [0:3]  destRegisterSpecialIn,
    input  logic        destRegisterSpecialValidIn,
    input  logic        wbValidIn,
    input  logic [0:3]  wbRegIn,
    input  logic        wbRegValidIn,
    input  logic [0:3]  wbSpecialRegIn,
    input  logic        wbSpecialRegValidIn,
    output logic        readStallOut,
    output logic        issueAcceptOut,
    output logic [15:0] pendingMaskOut,
    output logic        busyOut,
    output logic        underflowErrOut
);

    localparam logic [1:0] MAX_CNT = 2'(MAX_PENDING);
    localparam logic [3:0] RSP_REG = 4'd4;

    logic [1:0]  count_q [16];
    logic [1:0]  count_d [16];
    logic [15:0] pend_mask_q;
    logic [15:0] pend_mask_d;
    logic        busy_q;
    logic        busy_d;
    logic        underflow_q;
    logic        underflow_d;

    logic [15:0] dec_s;       // register retires this cycle
    logic [15:0] inc_s;       // register gains an in-flight write this cycle
    logic [15:0] src_busy_s;  // reading this register must wait
    logic [15:0] dst_full_s;  // register has no room for another write
    logic        is_retq_s;
    logic        stall_s;
    logic        accept_s;

    // Retiring registers. Equal reg and special codes collapse to one decrement.
    always_comb begin
        dec_s = 16'h0000;
        for (int r = 0; r < 16; r++) begin
            dec_s[r] = wbValidIn &&
                       ((wbRegValidIn && (wbRegIn == 4'(r))) ||
                        (wbSpecialRegValidIn && (wbSpecialRegIn == 4'(r))));
        end
    end

    // Per-register read hazard and write-saturation status.
    always_comb begin
        src_busy_s = 16'h0000;
        dst_full_s = 16'h0000;
        for (int r = 0; r < 16; r++) begin
`ifdef READ_SCOREBOARD_WB_BYPASS_EN
            // The last outstanding write retiring now is visible through the
            // register-file write-through, so it no longer blocks the read.
            src_busy_s[r] = (count_q[r] != 2'd0) &&
                            !((count_q[r] == 2'd1) && dec_s[r]);
`else
            src_busy_s[r] = (count_q[r] != 2'd0);
`endif
            dst_full_s[r] = (count_q[r] == MAX_CNT);
        end
    end

    assign is_retq_s = (opcodeLengthIn == 32'd1) && (opcodeIn == 8'hC3);

    // Sources stall on any pending write. Destinations stall only when full,
    // because WAW order is preserved by in-order write-back.
    assign stall_s = issueValidIn &&
                     ((sourceReg1ValidIn && src_busy_s[sourceReg1In]) ||
                      (sourceReg2ValidIn && src_busy_s[sourceReg2In]) ||
                      (is_retq_s && src_busy_s[RSP_REG]) ||
                      (destRegValidIn && dst_full_s[destRegIn]) ||
                      (destRegisterSpecialValidIn && dst_full_s[destRegisterSpecialIn]));

    assign accept_s = issueValidIn && !stall_s;

    // New in-flight writes. Equal dest and special codes collapse to one increment.
    always_comb begin
        inc_s = 16'h0000;
        for (int r = 0; r < 16; r++) begin
            inc_s[r] = accept_s &&
                       ((destRegValidIn && (destRegIn == 4'(r))) ||
                        (destRegisterSpecialValidIn && (destRegisterSpecialIn == 4'(r))));
        end
    end

    // Count next-state, pending mask, busy and underflow detection.
    always_comb begin
        underflow_d = underflow_q;
        pend_mask_d = 16'h0000;
        for (int r = 0; r < 16; r++) begin
            count_d[r] = count_q[r];
            case ({inc_s[r], dec_s[r]})
                2'b10: begin
                    if (count_q[r] != MAX_CNT) begin
                        count_d[r] = count_q[r] + 2'd1;
                    end else begin
                        count_d[r] = count_q[r];
                    end
                end
                2'b01: begin
                    if (count_q[r] == 2'd0) begin
                        underflow_d = 1'b1;
                    end else begin
                        count_d[r] = count_q[r] - 2'd1;
                    end
                end
                2'b11: begin
                    // Increment and decrement cancel. A zero count is still an
                    // unmatched write-back.
                    if (count_q[r] == 2'd0) begin
                        underflow_d = 1'b1;
                    end else begin
                        count_d[r] = count_q[r];
                    end
                end
                default: begin
                    count_d[r] = count_q[r];
                end
            endcase
            pend_mask_d[r] = (count_d[r] != 2'd0);
        end
        busy_d = |pend_mask_d;
    end

    // State registers. Reset beats flush, and flush drops same-cycle issue/write-back.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < 16; r++) begin
                count_q[r] <= 2'd0;
            end
            pend_mask_q <= 16'h0000;
            busy_q      <= 1'b0;
            underflow_q <= 1'b0;
        end else if (flushIn) begin
            for (int r = 0; r < 16; r++) begin
                count_q[r] <= 2'd0;
            end
            pend_mask_q <= 16'h0000;
            busy_q      <= 1'b0;
            underflow_q <= underflow_q;
        end else begin
            for (int r = 0; r < 16; r++) begin
                count_q[r] <= count_d[r];
            end
            pend_mask_q <= pend_mask_d;
            busy_q      <= busy_d;
            underflow_q <= underflow_d;
        end
    end

    assign readStallOut    = stall_s;
    assign issueAcceptOut  = accept_s;
    assign pendingMaskOut  = pend_mask_q;
    assign busyOut         = busy_q;
    assign underflowErrOut = underflow_q;

endmodule

// File: tb/tb_read_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_read_scoreboard
//
// Directed, table-driven bench for read_scoreboard. Each table row is applied
// for one clock. The combinational outputs are checked against the row's
// inputs. The registered outputs are checked against the state left by the
// earlier rows. Hand-written sequences cover the reset state and the
// dependent-instruction bubble.
// -----------------------------------------------------------------------------
module tb_read_scoreboard;

`ifdef READ_SCOREBOARD_WB_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        flushIn;
    logic        issueValidIn;
    logic [0:3]  sourceReg1In;
    logic [0:3]  sourceReg2In;
    logic        sourceReg1ValidIn;
    logic        sourceReg2ValidIn;
    logic [0:31] opcodeLengthIn;
    logic [0:7]  opcodeIn;
    logic [0:3]  destRegIn;
    logic        destRegValidIn;
    logic [0:3]  destRegisterSpecialIn;
    logic        destRegisterSpecialValidIn;
    logic        wbValidIn;
    logic [0:3]  wbRegIn;
    logic        wbRegValidIn;
    logic [0:3]  wbSpecialRegIn;
    logic        wbSpecialRegValidIn;
    logic        readStallOut;
    logic        issueAcceptOut;
    logic [15:0] pendingMaskOut;
    logic        busyOut;
    logic        underflowErrOut;

    read_scoreboard #(.MAX_PENDING(3)) dut (
        .clk                        (clk),
        .reset                      (reset),
        .flushIn                    (flushIn),
        .issueValidIn               (issueValidIn),
        .sourceReg1In               (sourceReg1In),
        .sourceReg2In               (sourceReg2In),
        .sourceReg1ValidIn          (sourceReg1ValidIn),
        .sourceReg2ValidIn          (sourceReg2ValidIn),
        .opcodeLengthIn             (opcodeLengthIn),
        .opcodeIn                   (opcodeIn),
        .destRegIn                  (destRegIn),
        .destRegValidIn             (destRegValidIn),
        .destRegisterSpecialIn      (destRegisterSpecialIn),
        .destRegisterSpecialValidIn (destRegisterSpecialValidIn),
        .wbValidIn                  (wbValidIn),
        .wbRegIn                    (wbRegIn),
        .wbRegValidIn               (wbRegValidIn),
        .wbSpecialRegIn             (wbSpecialRegIn),
        .wbSpecialRegValidIn        (wbSpecialRegValidIn),
        .readStallOut               (readStallOut),
        .issueAcceptOut             (issueAcceptOut),
        .pendingMaskOut             (pendingMaskOut),
        .busyOut                    (busyOut),
        .underflowErrOut            (underflowErrOut)
    );

    // 10 ns clock; first rising edge at 5 ns.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ctl = {reset, flush, issueValid, retq}; register fields = {valid, code}
    typedef struct {
        string       name;
        logic [3:0]  ctl;
        logic [4:0]  s1;
        logic [4:0]  s2;
        logic [4:0]  d;
        logic [4:0]  sp;
        logic [4:0]  wr;
        logic [4:0]  ws;
        logic        e_stall;
        logic [15:0] e_mask;
        logic        e_uf;
    } vec_t;

    localparam logic [3:0] C_NONE = 4'b0000;
    localparam logic [3:0] C_IV   = 4'b0010;
    localparam logic [3:0] C_RETQ = 4'b0011;
    localparam logic [3:0] C_FL   = 4'b0100;
    localparam logic [3:0] C_FLIV = 4'b0110;
    localparam logic [3:0] C_RSIV = 4'b1010;
    localparam logic [4:0] NO     = 5'd0;

    int   n_checks = 0;
    int   n_errors = 0;
    vec_t vecs[$];

    function automatic logic [4:0] R(input int r);
        return {1'b1, 4'(r)};
    endfunction

    function automatic vec_t mk(input string nm, input logic [3:0] ctl,
                                input logic [4:0] s1, input logic [4:0] s2,
                                input logic [4:0] d, input logic [4:0] sp,
                                input logic [4:0] wr, input logic [4:0] ws,
                                input logic e_stall, input logic [15:0] e_mask,
                                input logic e_uf);
        vec_t v;
        v.name = nm; v.ctl = ctl; v.s1 = s1; v.s2 = s2; v.d = d; v.sp = sp;
        v.wr = wr; v.ws = ws; v.e_stall = e_stall; v.e_mask = e_mask; v.e_uf = e_uf;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        reset                      = v.ctl[3];
        flushIn                    = v.ctl[2];
        issueValidIn               = v.ctl[1];
        opcodeLengthIn             = v.ctl[0] ? 32'd1 : 32'd2;  // C3 with length 2 is not RETQ
        opcodeIn                   = 8'hC3;
        sourceReg1ValidIn          = v.s1[4];
        sourceReg1In               = v.s1[3:0];
        sourceReg2ValidIn          = v.s2[4];
        sourceReg2In               = v.s2[3:0];
        destRegValidIn             = v.d[4];
        destRegIn                  = v.d[3:0];
        destRegisterSpecialValidIn = v.sp[4];
        destRegisterSpecialIn      = v.sp[3:0];
        wbValidIn                  = v.wr[4] | v.ws[4];
        wbRegValidIn               = v.wr[4];
        wbRegIn                    = v.wr[3:0];
        wbSpecialRegValidIn        = v.ws[4];
        wbSpecialRegIn             = v.ws[3:0];
    endtask

    task automatic chk(input string nm, input string what,
                       input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s.%s: got %h expected %h", nm, what, act, exp);
        end
    endtask

    task automatic chk_all(input string nm, input logic e_stall, input logic e_acc,
                           input logic [15:0] e_mask, input logic e_uf);
        chk(nm, "stall",  16'(readStallOut),    16'(e_stall));
        chk(nm, "accept", 16'(issueAcceptOut),  16'(e_acc));
        chk(nm, "mask",   pendingMaskOut,       e_mask);
        chk(nm, "busy",   16'(busyOut),         16'(e_mask != 16'h0000));
        chk(nm, "uflow",  16'(underflowErrOut), 16'(e_uf));
    endtask

    initial begin
        int  stalls;
        logic released;

        // Rows: name, ctl, s1, s2, d, sp, wr, ws, stall, mask (state before row), uflow
        vecs.push_back(mk("idle_src3",   C_IV,   R(3), NO,   NO,    NO,   NO,   NO,   1'b0, 16'h0000, 1'b0));
        vecs.push_back(mk("acc_d2",      C_IV,   NO,   NO,   R(2),  NO,   NO,   NO,   1'b0, 16'h0000, 1'b0));
        vecs.push_back(mk("raw_hold1",   C_IV,   R(2), NO,   NO,    NO,   NO,   NO,   1'b1, 16'h0004, 1'b0));
        vecs.push_back(mk("raw_hold2",   C_IV,   R(2), NO,   NO,    NO,   NO,   NO,   1'b1, 16'h0004, 1'b0));
        vecs.push_back(mk("raw_wb",      C_IV,   R(2), NO,   NO,    NO,   R(2), NO,   !BYP, 16'h0004, 1'b0));
        vecs.push_back(mk("raw_free",    C_IV,   R(2), NO,   NO,    NO,   NO,   NO,   1'b0, 16'h0000, 1'b0));
        vecs.push_back(mk("imul",        C_IV,   NO,   NO,   R(0),  R(2), NO,   NO,   1'b0, 16'h0000, 1'b0));
        vecs.push_back(mk("imul_mask",   C_NONE, NO,   NO,   NO,    NO,   NO,   NO,   1'b0, 16'h0005, 1'b0));
        vecs.push_back(mk("imul_wb",     C_NONE, NO,   NO,   NO,    NO,   R(0), R(2), 1'b0, 16'h0005, 1'b0));
        vecs.push_back(mk("acc_d4",      C_IV,   NO,   NO,   R(4),  NO,   NO,   NO,   1'b0, 16'h0000, 1'b0));
        vecs.push_back(mk("c3_len2",     C_IV,   NO,   NO,   NO,    NO,   NO,   NO,   1'b0, 16'h0010, 1'b0));
        vecs.push_back(mk("retq_hold",   C_RETQ, NO,   NO,   NO,    NO,   NO,   NO,   1'b1, 16'h0010, 1'b0));
        vecs.push_back(mk("retq_wb",     C_RETQ, NO,   NO,   NO,    NO,   R(4), NO,   !BYP, 16'h0010, 1'b0));
        vecs.push_back(mk("retq_go",     C_RETQ, NO,   NO,   NO,    NO,   NO,   NO,   1'b0, 16'h0000, 1'b0));
        vecs.push_back(mk("d5_a",        C_IV,   NO,   NO,   R(5),  NO,   NO,   NO,   1'b0, 16'h0000, 1'b0));
        vecs.push_back(mk("d5_b",        C_IV,   NO,   NO,   R(5),  NO,   NO,   NO,   1'b0, 16'h0020, 1'b0));
        vecs.push_back(mk("d5_c",        C_IV,   NO,   NO,   R(5),  NO,   NO,   NO,   1'b0, 16'h0020, 1'b0));
        vecs.push_back(mk("d5_full",     C_IV,   NO,   NO,   R(5),  NO,   NO,   NO,   1'b1, 16'h0020, 1'b0));
        vecs.push_back(mk("d5_full_wb",  C_IV,   NO,   NO,   R(5),  NO,   R(5), NO,   1'b1, 16'h0020, 1'b0));
        vecs.push_back(mk("d5_acc_wb",   C_IV,   NO,   NO,   R(5),  NO,   R(5), NO,   1'b0, 16'h0020, 1'b0));
        vecs.push_back(mk("d5_refill",   C_IV,   NO,   NO,   R(5),  NO,   NO,   NO,   1'b0, 16'h0020, 1'b0));
        vecs.push_back(mk("d5_full2",    C_IV,   NO,   NO,   R(5),  NO,   NO,   NO,   1'b1, 16'h0020, 1'b0));
        vecs.push_back(mk("s2_r5",       C_IV,   NO,   R(5), NO,    NO,   NO,   NO,   1'b1, 16'h0020, 1'b0));
        vecs.push_back(mk("wb5_dup",     C_NONE, NO,   NO,   NO,    NO,   R(5), R(5), 1'b0, 16'h0020, 1'b0));
        vecs.push_back(mk("d5_after_dup",C_IV,   NO,   NO,   R(5),  NO,   NO,   NO,   1'b0, 16'h0020, 1'b0));
        vecs.push_back(mk("d5_full3",    C_IV,   NO,   NO,   R(5),  NO,   NO,   NO,   1'b1, 16'h0020, 1'b0));
        vecs.push_back(mk("drain1",      C_NONE, NO,   NO,   NO,    NO,   R(5), NO,   1'b0, 16'h0020, 1'b0));
        vecs.push_back(mk("drain2",      C_NONE, NO,   NO,   NO,    NO,   R(5), NO,   1'b0, 16'h0020, 1'b0));
        vecs.push_back(mk("drain3",      C_NONE, NO,   NO,   NO,    NO,   R(5), NO,   1'b0, 16'h0020, 1'b0));
        vecs.push_back(mk("d6_sp6",      C_IV,   NO,   NO,   R(6),  R(6), NO,   NO,   1'b0, 16'h0000, 1'b0));
        vecs.push_back(mk("wb6",         C_NONE, NO,   NO,   NO,    NO,   R(6), NO,   1'b0, 16'h0040, 1'b0));
        vecs.push_back(mk("post_wb6",    C_NONE, NO,   NO,   NO,    NO,   NO,   NO,   1'b0, 16'h0000, 1'b0));
        vecs.push_back(mk("uf_wb7",      C_NONE, NO,   NO,   NO,    NO,   R(7), NO,   1'b0, 16'h0000, 1'b0));
        vecs.push_back(mk("uf_set",      C_NONE, NO,   NO,   NO,    NO,   NO,   NO,   1'b0, 16'h0000, 1'b1));
        vecs.push_back(mk("acc_d1",      C_IV,   NO,   NO,   R(1),  NO,   NO,   NO,   1'b0, 16'h0000, 1'b1));
        vecs.push_back(mk("acc_d2b",     C_IV,   NO,   NO,   R(2),  NO,   NO,   NO,   1'b0, 16'h0002, 1'b1));
        vecs.push_back(mk("acc_d3",      C_IV,   NO,   NO,   R(3),  NO,   NO,   NO,   1'b0, 16'h0006, 1'b1));
        vecs.push_back(mk("flush_d9",    C_FLIV, NO,   NO,   R(9),  NO,   NO,   NO,   1'b0, 16'h000E, 1'b1));
        vecs.push_back(mk("post_flush",  C_NONE, NO,   NO,   NO,    NO,   NO,   NO,   1'b0, 16'h0000, 1'b1));
        vecs.push_back(mk("acc_d8",      C_IV,   NO,   NO,   R(8),  NO,   NO,   NO,   1'b0, 16'h0000, 1'b1));
        vecs.push_back(mk("s8_stall",    C_IV,   R(8), NO,   NO,    NO,   NO,   NO,   1'b1, 16'h0100, 1'b1));
        vecs.push_back(mk("rst_mid",     C_RSIV, R(8), NO,   NO,    NO,   NO,   NO,   1'b1, 16'h0100, 1'b1));
        vecs.push_back(mk("post_rst",    C_IV,   R(8), NO,   NO,    NO,   NO,   NO,   1'b0, 16'h0000, 1'b0));
        vecs.push_back(mk("acc_d8b",     C_IV,   NO,   NO,   R(8),  NO,   NO,   NO,   1'b0, 16'h0000, 1'b0));
        vecs.push_back(mk("s8_stall2",   C_IV,   R(8), NO,   NO,    NO,   NO,   NO,   1'b1, 16'h0100, 1'b0));
        vecs.push_back(mk("flush_mid",   C_FLIV, R(8), NO,   NO,    NO,   NO,   NO,   1'b1, 16'h0100, 1'b0));
        vecs.push_back(mk("post_flush2", C_IV,   R(8), NO,   NO,    NO,   NO,   NO,   1'b0, 16'h0000, 1'b0));
        vecs.push_back(mk("flush_wb7",   C_FL,   NO,   NO,   NO,    NO,   R(7), NO,   1'b0, 16'h0000, 1'b0));
        vecs.push_back(mk("post_fl_wb7", C_NONE, NO,   NO,   NO,    NO,   NO,   NO,   1'b0, 16'h0000, 1'b0));

        // Reset state.
        apply(mk("rst", 4'b1000, NO, NO, NO, NO, NO, NO, 1'b0, 16'h0000, 1'b0));
        @(posedge clk); #1;
        @(posedge clk); #1;
        apply(mk("idle", C_NONE, NO, NO, NO, NO, NO, NO, 1'b0, 16'h0000, 1'b0));
        #2;
        chk_all("reset_state", 1'b0, 1'b0, 16'h0000, 1'b0);
        @(posedge clk); #1;

        // Table: drive, let the comb outputs settle, compare, then clock.
        foreach (vecs[i]) begin
            apply(vecs[i]);
            #2;
            chk_all(vecs[i].name, vecs[i].e_stall,
                    vecs[i].ctl[1] && !vecs[i].e_stall, vecs[i].e_mask, vecs[i].e_uf);
            @(posedge clk); #1;
        end

        // Bubble: producer writes r10. Consumer reads r10 every cycle, and r10
        // retires in the consumer's third cycle (index 2). Without bypass the
        // consumer stalls in cycles 0..2. With bypass it also goes in cycle 2.
        apply(mk("prod", C_IV, NO, NO, R(10), NO, NO, NO, 1'b0, 16'h0000, 1'b0));
        #2;
        chk("bubble_prod", "accept", 16'(issueAcceptOut), 16'd1);
        @(posedge clk); #1;
        stalls   = 0;
        released = 1'b0;
        for (int c = 0; c < 10; c++) begin
            apply(mk("cons", C_IV, R(10), NO, NO, NO, (c == 2) ? R(10) : NO, NO,
                     1'b0, 16'h0000, 1'b0));
            #2;
            if (!readStallOut) begin
                released = 1'b1;
                chk("bubble", "accept_on_release", 16'(issueAcceptOut), 16'd1);
                break;
            end
            stalls++;
            @(posedge clk); #1;
        end
        chk("bubble", "released", 16'(released), 16'd1);
        chk("bubble", "stall_cycles", 16'(stalls), BYP ? 16'd2 : 16'd3);
        @(posedge clk); #1;
        apply(mk("idle", C_NONE, NO, NO, NO, NO, NO, NO, 1'b0, 16'h0000, 1'b0));
        #2;
        chk("bubble", "mask_after", pendingMaskOut, 16'h0000);
        chk("bubble", "uflow_after", 16'(underflowErrOut), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
